// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: op types, FSM states, strobe
// constants and the registered bundle/request layouts.
package memory_stage_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    ST_SW  = 3'b000,
    ST_SB  = 3'b001,
    ST_SH  = 3'b010,
    ST_SWL = 3'b011,
    ST_SWR = 3'b100
  } store_type_e;

  // Load types are only carried through to writeback, which decodes them.
  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100,
    LD_LWL = 3'b101,
    LD_LWR = 3'b110
  } load_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [NUM_LANES-1:0] STRB_NONE    = 4'b0000;
  localparam logic [NUM_LANES-1:0] STRB_ALL     = 4'b1111;
  localparam logic [NUM_LANES-1:0] STRB_B0      = 4'b0001;
  localparam logic [NUM_LANES-1:0] STRB_LO_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] STRB_HI_HALF = 4'b1100;

  typedef struct packed {
    logic        reg_en;
    logic [5:0]  reg_waddr;
    logic        mem_read;
    logic [31:0] alu_result;
    logic        md_complete;
    logic [63:0] md_result;
    logic [2:0]  load_type;
    logic [31:0] rt_data;
  } wb_bundle_t;

  typedef struct packed {
    logic                 wr;
    logic [NUM_LANES-1:0] wstrb;
    logic [31:0]          wdata;
  } sram_req_t;

endpackage

// File: rtl/memory_stage_store_align.sv
// Store lane steering: maps store type, byte offset and rt to SRAM byte
// strobes and lane-positioned write data.
module store_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]           store_type,
  input  logic [1:0]           a,
  input  logic [31:0]          rt,
  output logic [NUM_LANES-1:0] wstrb,
  output logic [31:0]          wdata
);

  always_comb begin
    wstrb = STRB_NONE;
    wdata = rt;
    case (store_type)
      ST_SW:  wstrb = STRB_ALL;
      ST_SB: begin
        wstrb = STRB_B0 << a;
        wdata = {4{rt[7:0]}};
      end
      ST_SH: begin
        wstrb = a[1] ? STRB_HI_HALF : STRB_LO_HALF;
        wdata = {2{rt[15:0]}};
      end
      // SWL fills lanes 0..a with the top bytes of rt; SWR fills lanes a..3
      // with the bottom bytes.
      ST_SWL: begin
        wstrb = STRB_ALL >> (2'd3 - a);
        wdata = rt >> {2'd3 - a, 3'b000};
      end
      ST_SWR: begin
        wstrb = STRB_ALL << a;
        wdata = rt << {a, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Execute->writeback memory stage: captures the execute bundle, runs one
// SRAM request/response per memory op, presents a one-cycle result.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_en,
  input  logic [5:0]        in_reg_waddr,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_load_type,
  input  logic [2:0]        in_store_type,
  input  logic [31:0]       in_alu_result,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              in_MD_complete,
  input  logic [63:0]       in_MD_result,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stop,
  output logic              exe_reg_en,
  output logic [5:0]        exe_reg_waddr,
  output logic              exe_mem_read,
  output logic [31:0]       alu_result_reg,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              exe_MD_complete,
  output logic [63:0]       exe_MD_result,
  output logic [2:0]        exe_load_type,
  output logic [DATA_W-1:0] exe_load_rt_data
);

  state_e                state, state_nxt;
  wb_bundle_t            wb_q;
  sram_req_t             req_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_LANES-1:0]  al_wstrb;
  logic [31:0]           al_wdata;
  logic                  accept, mem_op, resp_fire;

  assign accept = in_valid & in_ready;
  assign mem_op = in_mem_read | in_mem_write;
  // A response only counts once the request itself has been taken.
  assign resp_fire = data_data_ok &
                     ((state == S_WAIT) | ((state == S_REQ) & data_addr_ok));

  store_align u_store_align (
    .store_type (in_store_type),
    .a          (in_alu_result[1:0]),
    .rt         (in_rt_data),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    data_req  = 1'b0;
    stop      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = mem_op ? S_REQ : S_DONE;
      end
      S_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) state_nxt = data_data_ok ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) state_nxt = S_DONE;
      end
      S_DONE: begin
        stop      = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bundle and payload registers move only on accept or response capture,
  // so the request payload is inherently stable across REQ/WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q    <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wb_q.reg_en      <= in_reg_en & ~in_mem_write;
        wb_q.reg_waddr   <= in_reg_waddr;
        wb_q.mem_read    <= in_mem_read;
        wb_q.alu_result  <= in_alu_result;
        wb_q.md_complete <= in_MD_complete;
        wb_q.md_result   <= in_MD_result;
        wb_q.load_type   <= in_load_type;
        wb_q.rt_data     <= in_rt_data;
        if (mem_op) begin
          addr_q      <= {in_alu_result[ADDR_W-1:2], 2'b00};
          req_q.wr    <= in_mem_write;
          req_q.wstrb <= in_mem_write ? al_wstrb : STRB_NONE;
          req_q.wdata <= in_mem_write ? al_wdata : '0;
        end
      end
      if (resp_fire && wb_q.mem_read) rdata_q <= data_rdata;
    end
  end

  assign data_wr          = req_q.wr;
  assign data_wstrb       = req_q.wstrb;
  assign data_wdata       = req_q.wdata;
  assign data_addr        = addr_q;

  assign exe_reg_en       = wb_q.reg_en;
  assign exe_reg_waddr    = wb_q.reg_waddr;
  assign exe_mem_read     = wb_q.mem_read;
  assign alu_result_reg   = wb_q.alu_result;
  assign mem_rdata        = rdata_q;
  assign exe_MD_complete  = wb_q.md_complete;
  assign exe_MD_result    = wb_q.md_result;
  assign exe_load_type    = wb_q.load_type;
  assign exe_load_rt_data = wb_q.rt_data;

endmodule

// File: tb/tb_memory_stage.sv
// Directed + randomized bench for memory_stage; a transaction-level model
// predicts the bundle, SRAM payload and cycle timing.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 0, in_ready;
  logic        in_reg_en = 0;
  logic [5:0]  in_reg_waddr = 0;
  logic        in_mem_read = 0, in_mem_write = 0;
  logic [2:0]  in_load_type = 0, in_store_type = 0;
  logic [31:0] in_alu_result = 0, in_rt_data = 0;
  logic        in_MD_complete = 0;
  logic [63:0] in_MD_result = 0;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok = 0, data_data_ok = 0;
  logic [31:0] data_rdata = 0;
  logic        stop, exe_reg_en, exe_mem_read, exe_MD_complete;
  logic [5:0]  exe_reg_waddr;
  logic [31:0] alu_result_reg, mem_rdata, exe_load_rt_data;
  logic [63:0] exe_MD_result;
  logic [2:0]  exe_load_type;

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_en(in_reg_en), .in_reg_waddr(in_reg_waddr),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_load_type(in_load_type), .in_store_type(in_store_type),
    .in_alu_result(in_alu_result), .in_rt_data(in_rt_data),
    .in_MD_complete(in_MD_complete), .in_MD_result(in_MD_result),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stop(stop), .exe_reg_en(exe_reg_en),
    .exe_reg_waddr(exe_reg_waddr), .exe_mem_read(exe_mem_read),
    .alu_result_reg(alu_result_reg), .mem_rdata(mem_rdata),
    .exe_MD_complete(exe_MD_complete), .exe_MD_result(exe_MD_result),
    .exe_load_type(exe_load_type), .exe_load_rt_data(exe_load_rt_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the writeback bundle
  logic        m_reg_en, m_mem_read, m_mdc;
  logic [5:0]  m_waddr;
  logic [31:0] m_alu, m_rdata, m_rt;
  logic [63:0] m_mdr;
  logic [2:0]  m_lt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg_en = 0; m_mem_read = 0; m_mdc = 0; m_waddr = 0;
    m_alu = 0; m_rdata = 0; m_rt = 0; m_mdr = 0; m_lt = 0;
  endtask

  // Byte-lane view of a store: which lanes are written and which rt byte
  // lands in each lane (unwritten SWL/SWR lanes carry zero).
  task automatic model_store(input logic [2:0] st, input logic [31:0] addr,
                             input logic [31:0] rt, output logic [3:0] strb,
                             output logic [31:0] wd);
    int a;
    a = int'(addr[1:0]);
    strb = 0; wd = 0;
    for (int i = 0; i < 4; i++) begin
      case (st)
        3'd0: begin strb[i] = 1'b1; wd[8*i +: 8] = rt[8*i +: 8]; end
        3'd1: begin strb[i] = (i == a); wd[8*i +: 8] = rt[7:0]; end
        3'd2: begin strb[i] = ((i / 2) == (a / 2)); wd[8*i +: 8] = rt[8*(i % 2) +: 8]; end
        3'd3: if (i <= a) begin strb[i] = 1'b1; wd[8*i +: 8] = rt[8*(3 - a + i) +: 8]; end
        3'd4: if (i >= a) begin strb[i] = 1'b1; wd[8*i +: 8] = rt[8*(i - a) +: 8]; end
        default: ;
      endcase
    end
  endtask

  task automatic check_bundle(input string tag);
    check({tag, ".stop"},    stop, 0);
    check({tag, ".reg_en"},  exe_reg_en, m_reg_en);
    check({tag, ".waddr"},   exe_reg_waddr, m_waddr);
    check({tag, ".mem_rd"},  exe_mem_read, m_mem_read);
    check({tag, ".alu"},     alu_result_reg, m_alu);
    check({tag, ".rdata"},   mem_rdata, m_rdata);
    check({tag, ".mdc"},     exe_MD_complete, m_mdc);
    check({tag, ".mdr"},     exe_MD_result, m_mdr);
    check({tag, ".ltype"},   exe_load_type, m_lt);
    check({tag, ".rt"},      exe_load_rt_data, m_rt);
  endtask

  task automatic scramble_inputs();
    in_reg_en = 1'($urandom); in_reg_waddr = 6'($urandom);
    in_load_type = 3'($urandom); in_store_type = 3'($urandom);
    in_alu_result = $urandom; in_rt_data = $urandom;
    in_MD_complete = 1'($urandom); in_MD_result = {$urandom, $urandom};
    in_mem_read = 0; in_mem_write = 0;
  endtask

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge of the cycle following DONE.
  task automatic run_txn(input string tag, input bit is_ld, input bit is_st,
                         input logic [2:0] st, input logic [2:0] lt,
                         input logic [31:0] addr, input logic [31:0] rt,
                         input logic [5:0] wa, input bit re, input bit mdc,
                         input logic [63:0] mdr, input int aw, input int dw,
                         input logic [31:0] rdata, input bit poke);
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    check({tag, ".ready"}, in_ready, 1);
    in_valid = 1; in_reg_en = re; in_reg_waddr = wa; in_mem_read = is_ld;
    in_mem_write = is_st; in_load_type = lt; in_store_type = st;
    in_alu_result = addr; in_rt_data = rt; in_MD_complete = mdc; in_MD_result = mdr;
    @(negedge clk);
    in_valid = 0;
    scramble_inputs();
    m_reg_en = re & ~is_st; m_waddr = wa; m_mem_read = is_ld; m_alu = addr;
    m_mdc = mdc; m_mdr = mdr; m_lt = lt; m_rt = rt;
    if (is_ld || is_st) begin
      if (is_st) model_store(st, addr, rt, e_strb, e_wd);
      else begin e_strb = 0; e_wd = 0; end
      for (int k = 0; k <= aw; k++) begin
        check({tag, ".req"},   data_req, 1);
        check({tag, ".addr"},  data_addr, {addr[31:2], 2'b00});
        check({tag, ".wr"},    data_wr, is_st);
        check({tag, ".wstrb"}, data_wstrb, e_strb);
        if (is_st) check({tag, ".wdata"}, data_wdata, e_wd);
        check({tag, ".busy"},  {stop, in_ready}, 2'b10);
        if (k == aw) begin
          data_addr_ok = 1;
          if (dw == 0) begin data_data_ok = 1; data_rdata = rdata; end
        end
        @(negedge clk);
        data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
      end
      for (int k = 0; k < dw; k++) begin
        check({tag, ".wait"}, {data_req, stop, in_ready}, 3'b010);
        check({tag, ".hold"}, data_addr, {addr[31:2], 2'b00});
        if (k == dw - 1) begin data_data_ok = 1; data_rdata = rdata; end
        @(negedge clk);
        data_data_ok = 0; data_rdata = $urandom;
      end
      if (is_ld) m_rdata = rdata;
    end
    check_bundle(tag);
    check({tag, ".done_rdy"}, in_ready, 0);
    if (poke) begin
      // Stray response and a new bundle during DONE must both be ignored.
      data_data_ok = 1; data_rdata = ~m_rdata;
      in_valid = 1; in_mem_read = 0; in_mem_write = 0;
    end
    @(negedge clk);
    data_data_ok = 0; in_valid = 0;
    check({tag, ".after"}, {stop, in_ready}, 2'b11);
    check({tag, ".after.rdata"}, mem_rdata, m_rdata);
    check({tag, ".after.alu"}, alu_result_reg, m_alu);
  endtask

  initial begin
    model_reset();
    #1 reset = 1;
    #1;
    check("rst.ctl", {stop, data_req, data_wr, in_ready}, 4'b1001);
    check("rst.payload", {data_wstrb, data_addr, data_wdata}, 68'h0);
    check_bundle_zero: begin
      check("rst.bundle", {exe_reg_en, exe_reg_waddr, exe_mem_read, alu_result_reg,
                           mem_rdata, exe_MD_complete}, 72'h0);
      check("rst.bundle2", {exe_MD_result, exe_load_type, exe_load_rt_data}, 99'h0);
    end
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Directed plan items
    run_txn("alu", 0, 0, 0, 0, 32'h1234, 32'h5, 6'd5, 1, 0, 64'h0, 0, 0, 0, 0);
    run_txn("sb", 0, 1, 3'd1, 0, 32'h1003, 32'hAABBCCDD, 6'd7, 1, 0, 0, 0, 0, 0, 0);
    run_txn("swl", 0, 1, 3'd3, 0, 32'h2001, 32'h11223344, 6'd1, 1, 0, 0, 1, 0, 0, 0);
    run_txn("swr", 0, 1, 3'd4, 0, 32'h2002, 32'h11223344, 6'd1, 0, 0, 0, 0, 1, 0, 1);
    run_txn("lw", 1, 0, 0, 3'd0, 32'h3000, 32'h9, 6'd9, 1, 1, 64'h1122_3344_5566_7788,
            3, 2, 32'hCAFEF00D, 0);
    run_txn("lw0", 1, 0, 0, 3'd2, 32'h4006, 32'h1, 6'd3, 1, 0, 0, 0, 0, 32'h0BADBEEF, 1);

    // Stray response while idle is ignored
    data_data_ok = 1; data_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    data_data_ok = 0;
    check("idle_ok.rdata", mem_rdata, m_rdata);
    check("idle_ok.ready", {stop, in_ready}, 2'b11);

    // Reset while a request is outstanding, then while waiting for data
    in_valid = 1; in_mem_read = 1; in_alu_result = 32'h500; in_reg_en = 1;
    @(negedge clk);
    in_valid = 0; scramble_inputs();
    check("rreq.req", data_req, 1);
    reset = 1; #1;
    model_reset();
    check("rreq.ctl", {data_req, stop, in_ready}, 3'b011);
    check("rreq.alu", alu_result_reg, m_alu);
    @(negedge clk); reset = 0; @(negedge clk);
    in_valid = 1; in_mem_read = 1; in_alu_result = 32'h600;
    @(negedge clk);
    in_valid = 0; scramble_inputs();
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0;
    check("rwait.state", {data_req, stop, in_ready}, 3'b010);
    reset = 1; #1;
    model_reset();
    check("rwait.ctl", {data_req, stop, in_ready}, 3'b011);
    check("rwait.rdata", mem_rdata, m_rdata);
    @(negedge clk); reset = 0; @(negedge clk);
    run_txn("post_rst", 0, 0, 0, 0, 32'hBEEF, 32'h77, 6'd12, 1, 1, 64'h42, 0, 0, 0, 0);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", n), kind == 1, kind == 2,
              3'($urandom_range(0, 4)), 3'($urandom_range(0, 6)), $urandom,
              $urandom, 6'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage between execute and writeback. Registers execute-stage results, issues load/store requests to the data SRAM over a request/response handshake, and generates store byte strobes and lane-replicated write data for SW/SB/SH/SWL/SWR. Presents a one-cycle-valid result bundle, plus a `stop` qualifier, to the writeback stage. Writeback performs all load-data extraction.

## Interface
Parameters:
- `ADDR_W`, 32, data address width.
- `DATA_W`, 32, data width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute bundle valid.
- `in_ready`  out  1  stage can accept a bundle.
- `in_reg_en`, `in_reg_waddr[5:0]`  in  1/6  register write enable and address.
- `in_mem_read`, `in_mem_write`  in  1/1  load op, store op; never both high.
- `in_load_type[2:0]`, `in_store_type[2:0]`  in  3/3  load type passed through; store type is SW=000, SB=001, SH=010, SWL=011, SWR=100.
- `in_alu_result[31:0]`  in  32  result value or effective address.
- `in_rt_data[31:0]`  in  32  store data, and old rt for LWL/LWR.
- `in_MD_complete`, `in_MD_result[63:0]`  in  1/64  multiply/divide result.
- `data_req`, `data_wr`  out  1/1  SRAM request and write flag.
- `data_wstrb[3:0]`, `data_addr[31:0]`, `data_wdata[31:0]`  out  request payload; address is word-aligned.
- `data_addr_ok`  in  1  request accepted this cycle.
- `data_data_ok`, `data_rdata[31:0]`  in  1/32  response (read data, or write ack).
- `stop`  out  1  high except in the cycle the output bundle is valid.
- `exe_reg_en`, `exe_reg_waddr`, `exe_mem_read`, `alu_result_reg`, `mem_rdata`, `exe_MD_complete`, `exe_MD_result`, `exe_load_type`, `exe_load_rt_data`  out  output bundle to writeback.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - REQ: `data_req`=1; the payload is held stable until `data_addr_ok`.
  - WAIT: awaiting `data_data_ok`.
  - DONE: output valid, `stop`=0, lasts one cycle.
- Accepting a bundle (`in_valid & in_ready`):
  - All fields are captured.
  - Non-memory op: IDLE→DONE.
  - Memory op: IDLE→REQ.
- Request and response transitions:
  - REQ→WAIT on `data_addr_ok`.
  - WAIT→DONE on `data_data_ok`; `mem_rdata` captures `data_rdata` (reads only).
  - If `data_addr_ok` and `data_data_ok` are both high in REQ, go directly REQ→DONE.
  - `data_data_ok` in IDLE or DONE is ignored.
- DONE→IDLE. No new bundle is accepted in DONE.
- `data_addr` = {addr[31:2],2'b00}. Loads use `data_wstrb`=0000 and `data_wr`=0. Let a = addr[1:0].
- Store strobes and write data:
  - SW: strb 1111, wdata=rt.
  - SB: strb=0001<<a, wdata={4{rt[7:0]}}.
  - SH: strb = a[1] ? 1100 : 0011, wdata={2{rt[15:0]}}.
  - SWL: strb for a=0..3 is 0001, 0011, 0111, 1111; wdata=rt>>(8·(3−a)).
  - SWR: strb for a=0..3 is 1111, 1110, 1100, 1000; wdata=rt<<(8·a).
- Stores complete in DONE with `exe_reg_en`=0.
- Misaligned addresses are not checked; the low bits select lanes as above.
- `exe_load_rt_data` = captured rt.

## Timing
- Reset: FSM=IDLE, `stop`=1, `data_req`=0, `data_wr`=0, `in_ready`=1, and every bundle output and SRAM payload output is 0.
- Non-memory latency: bundle accepted at edge N, output valid in cycle N+1, ready again in N+2.
- Memory latency: 1 + (cycles until `addr_ok`) + (cycles until `data_ok`) + 1 DONE cycle. With a zero-wait SRAM (both oks in the first REQ cycle) the result is valid in the second cycle after accept.
- Output bundle registers change only on accept or response capture. They hold their values while `stop`=1.
- Reset mid-transaction: return to IDLE at once and drop `data_req`. The SRAM is reset by the same signal, so no stale response arrives.

## Structure
- Shared package holds load and store type encodings, FSM state encoding and strobe constants.
- One sub-module, `store_align`, is combinational: {store_type, a, rt} → {wstrb, wdata}.

## Test plan
- ALU op, alu_result=0x1234, reg_en=1, waddr=5 → next cycle `stop`=0, `alu_result_reg`=0x1234, `exe_reg_en`=1; `stop`=1 the cycle after.
- SB at addr 0x1003, rt=0xAABBCCDD → `data_addr`=0x1000, wstrb=1000, wdata=0xDDDDDDDD, `data_wr`=1.
- SWL at a=1, rt=0x11223344 → wstrb=0011, wdata=0x00001122. SWR at a=2 → wstrb=1100, wdata=0x33440000.
- LW with `addr_ok` delayed 3 cycles and `data_ok` delayed 2 more, rdata=0xCAFEF00D → payload held throughout; `mem_rdata`=0xCAFEF00D in DONE; `in_ready`=0 until DONE+1.
- Zero-wait load, both oks in the same cycle → REQ→DONE directly; total 2 cycles from accept.
- Reset asserted while in WAIT → `data_req`=0, `stop`=1, `in_ready`=1 immediately; a following ALU op completes normally.
